// File: rtl/dcache_miss_ctrl_if.sv
// Pipeline, cache and memory signals seen by the data-cache miss sequencer.
// master = the miss controller, slave = pipeline/cache/memory side.
interface dcache_miss_ctrl_if #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    // pipeline / cache lookup side
    logic              me_mem_read;
    logic              me_mem_write;
    logic [31:0]       me_addr;
    logic              cache_hit;
    logic              cache_dirty;
    logic [31:0]       victim_base;
    // memory beat interface
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic              mem_ready;
    // cache data-array control
    logic              cache_wb_rd;
    logic              cache_fill_we;
    logic [IDX_W-1:0]  cache_word_idx;
    // pipeline control and statistics
    logic              stall_pipe;
    logic              me_wb_bubble;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  me_mem_read, me_mem_write, me_addr, cache_hit, cache_dirty,
               victim_base, mem_ready,
        output mem_req, mem_we, mem_addr, cache_wb_rd, cache_fill_we,
               cache_word_idx, stall_pipe, me_wb_bubble, miss_count
    );

    modport slave (
        output me_mem_read, me_mem_write, me_addr, cache_hit, cache_dirty,
               victim_base, mem_ready,
        input  mem_req, mem_we, mem_addr, cache_wb_rd, cache_fill_we,
               cache_word_idx, stall_pipe, me_wb_bubble, miss_count
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Memory-stage data-cache miss sequencer: freezes the pipeline on a miss,
// writes back a dirty victim, refills the line beat by beat, then spends one
// replay cycle so the cache can re-look-up before the access retires.
module dcache_miss_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    dcache_miss_ctrl_if.master bus
);
    localparam int               IDX_W     = $clog2(LINE_WORDS);
    localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WBACK,
        S_REFILL,
        S_REPLAY
    } state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] beat_reg, beat_next;
    logic [31:0]      line_addr_reg, line_addr_next;
    logic [CNT_W-1:0] miss_count_reg, miss_count_next;

    logic             access;
    logic             miss;
    logic [31:0]      beat_off;
    logic             mem_req_c;
    logic             mem_we_c;
    logic [31:0]      mem_addr_c;
    logic             wb_rd_c;
    logic             fill_we_c;
    logic             stall_c;

    // byte offset of the current beat within a line
    assign beat_off = {{(30 - IDX_W){1'b0}}, beat_reg, 2'b00};

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            beat_reg       <= '0;
            line_addr_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            line_addr_reg  <= line_addr_next;
            miss_count_reg <= miss_count_next;
        end
    end

    // Next-state and beat sequencing; all outputs forced low while in reset.
    always_comb begin
        state_next      = state_reg;
        beat_next       = beat_reg;
        line_addr_next  = line_addr_reg;
        miss_count_next = miss_count_reg;
        mem_req_c       = 1'b0;
        mem_we_c        = 1'b0;
        mem_addr_c      = '0;
        wb_rd_c         = 1'b0;
        fill_we_c       = 1'b0;
        stall_c         = 1'b0;
        access          = bus.me_mem_read | bus.me_mem_write;
        miss            = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                miss    = access & ~bus.cache_hit;
                stall_c = miss;
                if (miss) begin
                    line_addr_next  = bus.me_addr & ~LINE_MASK;
                    beat_next       = '0;
                    miss_count_next = (&miss_count_reg) ? miss_count_reg
                                                        : miss_count_reg + 1'b1;
                    state_next      = bus.cache_dirty ? S_WBACK : S_REFILL;
                end
            end
            S_WBACK: begin
                stall_c    = 1'b1;
                mem_req_c  = 1'b1;
                mem_we_c   = 1'b1;
                wb_rd_c    = 1'b1;
                mem_addr_c = bus.victim_base + beat_off;
                if (bus.mem_ready) begin
                    if (beat_reg == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = S_REFILL;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            S_REFILL: begin
                stall_c    = 1'b1;
                mem_req_c  = 1'b1;
                mem_addr_c = line_addr_reg + beat_off;
                fill_we_c  = bus.mem_ready;
                if (bus.mem_ready) begin
                    if (beat_reg == LAST_BEAT) begin
                        beat_next  = '0;
                        state_next = S_REPLAY;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            S_REPLAY: begin
                // cache re-looks-up the now-resident line; pipeline stays frozen
                stall_c    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (rst) begin
            mem_req_c  = 1'b0;
            mem_we_c   = 1'b0;
            mem_addr_c = '0;
            wb_rd_c    = 1'b0;
            fill_we_c  = 1'b0;
            stall_c    = 1'b0;
        end
    end

    assign bus.mem_req        = mem_req_c;
    assign bus.mem_we         = mem_we_c;
    assign bus.mem_addr       = mem_addr_c;
    assign bus.cache_wb_rd    = wb_rd_c;
    assign bus.cache_fill_we  = fill_we_c;
    assign bus.cache_word_idx = rst ? '0 : beat_reg;
    assign bus.stall_pipe     = stall_c;
    assign bus.me_wb_bubble   = stall_c;
    assign bus.miss_count     = rst ? '0 : miss_count_reg;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized bench for dcache_miss_ctrl: a random instruction stream runs
// against a small residency model of the cache; every miss is expanded into
// the expected list of memory beats and checked cycle by cycle.
module tb_dcache_miss_ctrl;
    localparam int LW   = 4;
    localparam int CW   = 4;
    localparam int NCYC = 6000;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  idx;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_miss_ctrl_if #(.LINE_WORDS(LW), .CNT_W(CW)) bus();
    dcache_miss_ctrl #(.LINE_WORDS(LW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    beat_t       bq[$];
    bit          replay_pend;
    int          exp_cnt;
    bit          res[16];
    logic        cur_rd, cur_wr;
    logic [31:0] cur_addr;
    int          cur_id;
    int          rmode;
    logic [31:0] vb_miss, line_miss;
    int          miss_id;
    bit          dirty_miss;
    int          stall_len;
    bit          lat_valid;
    int          nbeats;
    int          txn;
    bit          rst_now, rst_armed;
    logic        rdy;
    logic [31:0] vb_now;
    logic        dirty_now, hit_now;
    bit          acc, miss_now;
    int          ev;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_all(input string ph, input logic req, input logic we,
                              input logic [31:0] addr, input logic wb, input logic fw,
                              input logic st, input int cnt);
        check_val({ph, ".mem_req"},   32'(bus.mem_req),       32'(req));
        check_val({ph, ".mem_we"},    32'(bus.mem_we),        32'(we));
        check_val({ph, ".mem_addr"},  bus.mem_addr,           addr);
        check_val({ph, ".wb_rd"},     32'(bus.cache_wb_rd),   32'(wb));
        check_val({ph, ".fill_we"},   32'(bus.cache_fill_we), 32'(fw));
        check_val({ph, ".stall"},     32'(bus.stall_pipe),    32'(st));
        check_val({ph, ".bubble"},    32'(bus.me_wb_bubble),  32'(st));
        check_val({ph, ".miss_cnt"},  32'(bus.miss_count),    32'(cnt));
    endtask

    task automatic new_instr();
        int k;
        k        = $urandom_range(0, 3);
        cur_rd   = (k == 1 || k == 3);
        cur_wr   = (k == 2 || k == 3);
        cur_id   = $urandom_range(0, 15);
        cur_addr = 32'h100 + 32'(cur_id * 16) + 32'($urandom_range(0, 15));
    endtask

    initial begin
        rst              = 1'b1;
        bus.me_mem_read  = 1'b0;
        bus.me_mem_write = 1'b0;
        bus.me_addr      = '0;
        bus.cache_hit    = 1'b0;
        bus.cache_dirty  = 1'b0;
        bus.victim_base  = '0;
        bus.mem_ready    = 1'b0;
        foreach (res[i]) res[i] = 1'b0;
        res[0]      = 1'b1;          // first access: load hit at 0x100
        cur_rd      = 1'b1;
        cur_wr      = 1'b0;
        cur_id      = 0;
        cur_addr    = 32'h100;
        exp_cnt     = 0;
        replay_pend = 1'b0;
        rst_armed   = 1'b0;
        rmode       = 0;
        lat_valid   = 1'b0;
        txn         = 0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc     = c;
            rst_now = (c < 2) || (c > 50 && $urandom_range(0, 299) == 0);
            if (c == 3000) rst_armed = 1'b1;
            // reset in the middle of refill beat 2
            if (rst_armed && bq.size() > 0 && !bq[0].we && bq[0].idx == 2'd2) begin
                rst_now   = 1'b1;
                rst_armed = 1'b0;
            end
            rst = rst_now;

            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = c[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.mem_ready = rdy;

            if (bq.size() == 0 && !replay_pend) begin
                bus.me_mem_read  = cur_rd;
                bus.me_mem_write = cur_wr;
                bus.me_addr      = cur_addr;
                acc              = cur_rd | cur_wr;
                hit_now          = acc ? res[cur_id] : 1'($urandom_range(0, 1));
                dirty_now        = 1'($urandom_range(0, 1));
                vb_now           = $urandom & 32'hFFFF_FFF0;
                bus.cache_hit    = hit_now;
                bus.cache_dirty  = dirty_now;
                bus.victim_base  = vb_now;
            end else begin
                // frozen pipeline: anything on the lookup inputs must be ignored
                bus.me_mem_read  = 1'($urandom_range(0, 1));
                bus.me_mem_write = 1'($urandom_range(0, 1));
                bus.me_addr      = $urandom;
                bus.cache_hit    = 1'($urandom_range(0, 1));
                bus.cache_dirty  = 1'($urandom_range(0, 1));
                bus.victim_base  = (bq.size() > 0 && bq[0].we) ? vb_miss : $urandom;
            end
            #1;

            if (rst_now) begin
                expect_all("rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
                check_val("rst.idx", 32'(bus.cache_word_idx), 32'h0);
                bq.delete();
                replay_pend = 1'b0;
                exp_cnt     = 0;
                lat_valid   = 1'b0;
            end else if (bq.size() > 0) begin
                expect_all("beat", 1'b1, bq[0].we, bq[0].addr, bq[0].we,
                           !bq[0].we && rdy, 1'b1, exp_cnt);
                check_val("beat.idx", 32'(bus.cache_word_idx), 32'(bq[0].idx));
                stall_len++;
                if (rdy) begin
                    void'(bq.pop_front());
                    if (bq.size() == 0) begin
                        replay_pend = 1'b1;
                        res[miss_id] = 1'b1;
                        ev = $urandom_range(0, 15);
                        if (ev != miss_id) res[ev] = 1'b0;
                    end
                end
            end else if (replay_pend) begin
                expect_all("replay", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, exp_cnt);
                stall_len++;
                if (lat_valid) check_val("latency", 32'(stall_len), 32'(2 + nbeats));
                txn++;
                $display("txn %0d: miss line=%h dirty=%0d victim=%h ready_mode=%0d stall=%0d count=%0d",
                         txn, line_miss, dirty_miss, vb_miss, rmode, stall_len, exp_cnt);
                replay_pend = 1'b0;
            end else begin
                miss_now = acc && !hit_now;
                expect_all("idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, miss_now, exp_cnt);
                if (miss_now) begin
                    line_miss  = cur_addr & ~32'hF;
                    vb_miss    = vb_now;
                    dirty_miss = dirty_now;
                    miss_id    = cur_id;
                    if (dirty_now) begin
                        for (int i = 0; i < LW; i++)
                            bq.push_back('{we: 1'b1, addr: vb_now + 32'(4 * i), idx: 2'(i)});
                    end
                    for (int i = 0; i < LW; i++)
                        bq.push_back('{we: 1'b0, addr: line_miss + 32'(4 * i), idx: 2'(i)});
                    nbeats    = bq.size();
                    exp_cnt   = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
                    rmode     = $urandom_range(0, 2);
                    lat_valid = (rmode == 0);
                    stall_len = 1;
                end else begin
                    new_instr();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
